// File: rtl/narnet_stream_ctrl.sv
// narnet_stream_ctrl: sequencing front end for the 8-bit NARNet predictor.
// Measured S2.6 samples are buffered in a small FIFO and issued to the
// predictor one at a time. Each result is presented as a one-cycle strobe.
// When the FIFO is empty and closed-loop mode is on, predictions are fed
// back as inputs for a bounded number of steps.
module narnet_stream_ctrl #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic signed [7:0] s_data,
  output logic              s_ready,
  input  logic              cl_en,
  input  logic        [7:0] cl_steps,
  output logic signed [7:0] nn_x,
  output logic              nn_x_ready,
  input  logic signed [7:0] nn_y,
  input  logic              nn_out_ready,
  output logic              p_valid,
  output logic signed [7:0] p_data,
  output logic              p_src,
  output logic              overflow,
  output logic              timeout
);

  localparam int DATA_W = 8;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  mem [DEPTH];
  logic        [AW-1:0]      wr_ptr;
  logic        [AW-1:0]      rd_ptr;
  logic        [AW:0]        count;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      pop;
  logic        [7:0]         remaining;
  logic                      have_pred;
  logic signed [DATA_W-1:0]  last_pred;
  logic                      src;
  logic        [CW-1:0]      wait_cnt;
  logic                      nn_out_ready_q;
  logic                      done;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign s_ready = !full;
  assign push    = s_valid && s_ready;
  // IDLE always serves a waiting measured sample before anything else
  assign pop     = (state == IDLE) && !empty;
  // Only a fresh rising edge counts; a level left high from the previous
  // result is ignored until the predictor drops it on accepting new input
  assign done    = nn_out_ready && !nn_out_ready_q;

  // Sample storage; contents need no reset, occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // FIFO pointers, occupancy and the sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s_valid && full) overflow <= 1'b1;
    end
  end

  // Delayed copy of the predictor's done level, tracked through reset too
  always_ff @(posedge clk) begin
    nn_out_ready_q <= nn_out_ready;
  end

  // Transaction sequencer: IDLE -> ISSUE -> WAIT -> EMIT/IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      nn_x       <= '0;
      nn_x_ready <= 1'b0;
      p_valid    <= 1'b0;
      p_data     <= '0;
      p_src      <= 1'b0;
      remaining  <= '0;
      have_pred  <= 1'b0;
      src        <= 1'b0;
      wait_cnt   <= '0;
      timeout    <= 1'b0;
    end else begin
      nn_x_ready <= 1'b0;
      p_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            nn_x       <= mem[rd_ptr];
            remaining  <= cl_steps;
            src        <= 1'b0;
            nn_x_ready <= 1'b1;
            state      <= ISSUE;
          end else if (cl_en && (remaining != 8'd0) && have_pred) begin
            nn_x       <= last_pred;
            remaining  <= remaining - 8'd1;
            src        <= 1'b1;
            nn_x_ready <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (done) begin
            last_pred <= nn_y;
            have_pred <= 1'b1;
            p_valid   <= 1'b1;
            p_data    <= nn_y;
            p_src     <= src;
            state     <= EMIT;
          end else if (wait_cnt == WAIT_MAX) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        EMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
